// File: rtl/neuron_sched.sv
// neuron_sched: sequences the neuron SRAM read/write sweeps for AER spike events,
// per-time-step leak sweeps and the end-of-sample refractory passes.
module neuron_sched #(
  parameter int TIME_STEP            = 8,
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            START,
  input  logic                            AER_VALID,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]  AER_ADDR,
  output logic                            AER_READY,
  input  logic                            STEP_END,
  input  logic [POST_NEUR_PARALLEL-1:0]   NEUR_EVENT_IN,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] SYN_ADDR,
  output logic                            CTRL_PRE_NEUR_CS,
  output logic                            CTRL_PRE_NEUR_WE,
  output logic                            CTRL_POST_NEUR_CS,
  output logic                            CTRL_POST_NEUR_WE,
  output logic                            CTRL_PRE_CNT_EN,
  output logic                            CTRL_NEUR_EVENT,
  output logic                            CTRL_TSTEP_EVENT,
  output logic                            CTRL_TREF_EVENT,
  output logic                            SPK_VALID,
  output logic [5:0]                      SPK_GRP,
  output logic [POST_NEUR_PARALLEL-1:0]   SPK_MASK,
  output logic                            BUSY,
  output logic                            DONE
);

  localparam int NGRP   = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int STEP_W = $clog2(TIME_STEP + 1);
  localparam logic [31:0] PAR_U  = 32'(POST_NEUR_PARALLEL);
  localparam logic [31:0] NGRP_U = 32'(NGRP);

  typedef enum logic [3:0] {
    IDLE, WAIT_EV, PRE_RD, PRE_WR, POST_RD, POST_WR, STEP_RD, STEP_WR,
    REF_PRE_RD, REF_PRE_WR, REF_POST_RD, REF_POST_WR, FIN
  } state_t;

  state_t                           state, state_nxt;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]   pre_reg, pre_nxt;
  logic [GRP_W-1:0]                 grp, grp_nxt;
  logic [STEP_W-1:0]                step_cnt, step_nxt;
  logic [POST_NEUR_ADDR_WIDTH-1:0]  post_addr_q, post_addr_nxt;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]  syn_addr_q, syn_addr_nxt;
  logic                             last_grp, last_pre, last_step, spk_en;

  assign last_grp  = (grp == GRP_W'(NGRP - 1));
  assign last_pre  = (pre_reg == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1));
  assign last_step = (step_cnt == STEP_W'(TIME_STEP - 1));

  assign CTRL_PRE_NEURON_ADDRESS  = pre_reg;
  assign CTRL_POST_NEURON_ADDRESS = post_addr_q;
  assign SYN_ADDR                 = syn_addr_q;
  assign BUSY                     = (state != IDLE);

  // Addresses are registered from the next-cycle counters so they are already
  // valid in each RD state and stay put through the matching WR state.
  always_comb begin
    post_addr_nxt = POST_NEUR_ADDR_WIDTH'(32'(grp_nxt) * PAR_U);
    syn_addr_nxt  = SYN_ARRAY_ADDR_WIDTH'(32'(pre_nxt) * NGRP_U + 32'(grp_nxt));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      pre_reg     <= '0;
      grp         <= '0;
      step_cnt    <= '0;
      post_addr_q <= '0;
      syn_addr_q  <= '0;
    end else begin
      state       <= state_nxt;
      pre_reg     <= pre_nxt;
      grp         <= grp_nxt;
      step_cnt    <= step_nxt;
      post_addr_q <= post_addr_nxt;
      syn_addr_q  <= syn_addr_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    pre_nxt           = pre_reg;
    grp_nxt           = grp;
    step_nxt          = step_cnt;
    AER_READY         = 1'b0;
    CTRL_PRE_NEUR_CS  = 1'b0;
    CTRL_PRE_NEUR_WE  = 1'b0;
    CTRL_POST_NEUR_CS = 1'b0;
    CTRL_POST_NEUR_WE = 1'b0;
    CTRL_PRE_CNT_EN   = 1'b0;
    CTRL_NEUR_EVENT   = 1'b0;
    CTRL_TSTEP_EVENT  = 1'b0;
    CTRL_TREF_EVENT   = 1'b0;
    DONE              = 1'b0;
    spk_en            = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          step_nxt  = '0;
          grp_nxt   = '0;
          state_nxt = WAIT_EV;
        end
      end
      // A pending event wins; a STEP_END arriving with it is dropped here.
      WAIT_EV: begin
        AER_READY = 1'b1;
        if (AER_VALID) begin
          pre_nxt   = AER_ADDR;
          state_nxt = PRE_RD;
        end else if (STEP_END) begin
          grp_nxt   = '0;
          state_nxt = STEP_RD;
        end
      end
      PRE_RD: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        state_nxt        = PRE_WR;
      end
      PRE_WR: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        CTRL_PRE_NEUR_WE = 1'b1;
        CTRL_PRE_CNT_EN  = 1'b1;
        CTRL_NEUR_EVENT  = 1'b1;
        spk_en           = 1'b1;
        grp_nxt          = '0;
        state_nxt        = POST_RD;
      end
      POST_RD: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_NEUR_EVENT   = 1'b1;
        state_nxt         = POST_WR;
      end
      POST_WR: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_POST_NEUR_WE = 1'b1;
        CTRL_NEUR_EVENT   = 1'b1;
        spk_en            = 1'b1;
        if (last_grp) begin
          grp_nxt   = '0;
          state_nxt = WAIT_EV;
        end else begin
          grp_nxt   = grp + GRP_W'(1);
          state_nxt = POST_RD;
        end
      end
      STEP_RD: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_TSTEP_EVENT  = 1'b1;
        state_nxt         = STEP_WR;
      end
      // The final step of a sample hands over to the refractory passes.
      STEP_WR: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_POST_NEUR_WE = 1'b1;
        CTRL_TSTEP_EVENT  = 1'b1;
        spk_en            = 1'b1;
        if (last_grp) begin
          grp_nxt  = '0;
          step_nxt = step_cnt + STEP_W'(1);
          if (last_step) begin
            pre_nxt   = '0;
            state_nxt = REF_PRE_RD;
          end else begin
            state_nxt = WAIT_EV;
          end
        end else begin
          grp_nxt   = grp + GRP_W'(1);
          state_nxt = STEP_RD;
        end
      end
      REF_PRE_RD: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        CTRL_TREF_EVENT  = 1'b1;
        state_nxt        = REF_PRE_WR;
      end
      REF_PRE_WR: begin
        CTRL_PRE_NEUR_CS = 1'b1;
        CTRL_PRE_NEUR_WE = 1'b1;
        CTRL_TREF_EVENT  = 1'b1;
        if (last_pre) begin
          grp_nxt   = '0;
          state_nxt = REF_POST_RD;
        end else begin
          pre_nxt   = pre_reg + PRE_NEUR_ADDR_WIDTH'(1);
          state_nxt = REF_PRE_RD;
        end
      end
      REF_POST_RD: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_TREF_EVENT   = 1'b1;
        state_nxt         = REF_POST_WR;
      end
      REF_POST_WR: begin
        CTRL_POST_NEUR_CS = 1'b1;
        CTRL_POST_NEUR_WE = 1'b1;
        CTRL_TREF_EVENT   = 1'b1;
        spk_en            = 1'b1;
        if (last_grp) begin
          grp_nxt   = '0;
          state_nxt = FIN;
        end else begin
          grp_nxt   = grp + GRP_W'(1);
          state_nxt = REF_POST_RD;
        end
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    SPK_VALID = spk_en & (|NEUR_EVENT_IN);
    SPK_GRP   = spk_en ? 6'(grp) : 6'd0;
    SPK_MASK  = spk_en ? NEUR_EVENT_IN : '0;
  end

endmodule

// File: tb/tb_neuron_sched.sv
// tb_neuron_sched: random AER/step traffic against a queue-based model of the
// expected SRAM write sequence, spikes and sample timing.
module tb_neuron_sched;

  localparam int TS   = 2;
  localparam int NIN  = 784;
  localparam int NOUT = 256;
  localparam int PAR  = 4;
  localparam int NG   = NOUT / PAR;
  localparam int FINAL_CYCLES = 2 * NG + 2 * NIN + 2 * NG + 1;

  logic        CLK = 1'b0;
  logic        RST, START, AER_VALID, STEP_END;
  logic [9:0]  AER_ADDR;
  logic        AER_READY;
  logic [3:0]  NEUR_EVENT_IN;
  logic [9:0]  CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS;
  logic [15:0] SYN_ADDR;
  logic        CTRL_PRE_NEUR_CS, CTRL_PRE_NEUR_WE, CTRL_POST_NEUR_CS, CTRL_POST_NEUR_WE;
  logic        CTRL_PRE_CNT_EN, CTRL_NEUR_EVENT, CTRL_TSTEP_EVENT, CTRL_TREF_EVENT;
  logic        SPK_VALID;
  logic [5:0]  SPK_GRP;
  logic [3:0]  SPK_MASK;
  logic        BUSY, DONE;

  logic [3:0]  seed;
  int          total_checks, passed_checks;
  int          done_seen, done_exp;
  int          model_step, last_pre;
  logic [42:0] post_q[$];
  logic [26:0] pre_q[$];

  neuron_sched #(.TIME_STEP(TS)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .AER_VALID(AER_VALID), .AER_ADDR(AER_ADDR), .AER_READY(AER_READY),
    .STEP_END(STEP_END), .NEUR_EVENT_IN(NEUR_EVENT_IN),
    .CTRL_PRE_NEURON_ADDRESS(CTRL_PRE_NEURON_ADDRESS),
    .CTRL_POST_NEURON_ADDRESS(CTRL_POST_NEURON_ADDRESS),
    .SYN_ADDR(SYN_ADDR),
    .CTRL_PRE_NEUR_CS(CTRL_PRE_NEUR_CS), .CTRL_PRE_NEUR_WE(CTRL_PRE_NEUR_WE),
    .CTRL_POST_NEUR_CS(CTRL_POST_NEUR_CS), .CTRL_POST_NEUR_WE(CTRL_POST_NEUR_WE),
    .CTRL_PRE_CNT_EN(CTRL_PRE_CNT_EN), .CTRL_NEUR_EVENT(CTRL_NEUR_EVENT),
    .CTRL_TSTEP_EVENT(CTRL_TSTEP_EVENT), .CTRL_TREF_EVENT(CTRL_TREF_EVENT),
    .SPK_VALID(SPK_VALID), .SPK_GRP(SPK_GRP), .SPK_MASK(SPK_MASK),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Stand-in neuron core: spike flags depend only on the addressed post group.
  function automatic logic [3:0] respond(input logic [9:0] addr, input logic [3:0] sd);
    logic [9:0] g, t;
    g = addr >> 2;
    if (g == 10'd9) return 4'b0101;
    t = (g * 10'd5) ^ {6'd0, sd} ^ (g >> 3);
    return t[3:0];
  endfunction

  assign NEUR_EVENT_IN = respond(CTRL_POST_NEURON_ADDRESS, seed);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic failTimeout(input string name);
    total_checks++;
    $display("[TB] FAIL %s: got no DUT response within bound, expected one", name);
  endtask

  function automatic logic [42:0] postRec(input logic [2:0] kind, input int g, input int pre);
    logic [3:0] m;
    logic [9:0] pa;
    pa = 10'(g * PAR);
    m  = respond(pa, seed);
    return {kind, 1'b0, 1'b1, 1'b0, pa, 16'(pre * NG + g), |m, 6'(g), m};
  endfunction

  function automatic void modelEvent(input int addr);
    logic [3:0] m0;
    m0 = respond(10'd0, seed);
    pre_q.push_back({6'b110010, 10'(addr), |m0, 6'd0, m0});
    for (int g = 0; g < NG; g++) post_q.push_back(postRec(3'b100, g, addr));
    last_pre = addr;
  endfunction

  function automatic bit modelStep();
    for (int g = 0; g < NG; g++) post_q.push_back(postRec(3'b010, g, last_pre));
    model_step++;
    if (model_step != TS) return 1'b0;
    for (int p = 0; p < NIN; p++) pre_q.push_back({6'b000110, 10'(p), 11'd0});
    last_pre = NIN - 1;
    for (int g = 0; g < NG; g++) post_q.push_back(postRec(3'b001, g, last_pre));
    done_exp++;
    return 1'b1;
  endfunction

  // Monitor: every SRAM write cycle is matched against the next expected write.
  always @(negedge CLK) begin
    logic [42:0] pe;
    logic [26:0] re;
    if (CTRL_POST_NEUR_WE) begin
      if (post_q.size() == 0) failTimeout("post_write_unexpected");
      else begin
        pe = post_q.pop_front();
        checkOutput("post_write", 64'({CTRL_NEUR_EVENT, CTRL_TSTEP_EVENT, CTRL_TREF_EVENT,
          CTRL_PRE_NEUR_CS, CTRL_POST_NEUR_CS, CTRL_PRE_CNT_EN, CTRL_POST_NEURON_ADDRESS,
          SYN_ADDR, SPK_VALID, SPK_GRP, SPK_MASK}), 64'(pe));
      end
    end
    if (CTRL_PRE_NEUR_WE) begin
      if (pre_q.size() == 0) failTimeout("pre_write_unexpected");
      else begin
        re = pre_q.pop_front();
        checkOutput("pre_write", 64'({CTRL_PRE_CNT_EN, CTRL_NEUR_EVENT, CTRL_TSTEP_EVENT,
          CTRL_TREF_EVENT, CTRL_PRE_NEUR_CS, CTRL_POST_NEUR_CS, CTRL_PRE_NEURON_ADDRESS,
          SPK_VALID, SPK_GRP, SPK_MASK}), 64'(re));
      end
    end
    if (!CTRL_POST_NEUR_WE && !CTRL_PRE_NEUR_WE)
      checkOutput("no_spike_outside_wr", 64'({SPK_VALID, CTRL_PRE_CNT_EN}), 64'd0);
    if (DONE) done_seen++;
  end

  task automatic waitReady(input string name);
    for (int i = 0; i < 6000; i++) begin
      if (AER_READY) return;
      @(negedge CLK);
    end
    failTimeout(name);
  endtask

  task automatic startSample();
    for (int i = 0; i < 6000 && BUSY; i++) @(negedge CLK);
    model_step = 0;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    checkOutput("start_state", 64'({BUSY, AER_READY, DONE}), 64'(3'b110));
  endtask

  task automatic finishStep(input bit last, input bit pulse_start);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      START = pulse_start && (i == 5);
      if (last ? !BUSY : AER_READY) begin
        seen = 1'b1;
        break;
      end
      cnt++;
    end
    START = 1'b0;
    if (!seen) failTimeout("step_completion");
    else if (last) begin
      checkOutput("final_pass_cycles", 64'(cnt), 64'(FINAL_CYCLES));
      checkOutput("done_count", 64'(done_seen), 64'(done_exp));
    end else checkOutput("step_sweep_cycles", 64'(cnt), 64'(2 * NG));
  endtask

  task automatic countEventBusy();
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (AER_READY) begin
        seen = 1'b1;
        break;
      end
      cnt++;
    end
    if (!seen) failTimeout("event_completion");
    else checkOutput("ready_low_cycles", 64'(cnt), 64'(2 + 2 * NG));
  endtask

  // kind 0: event, kind 1: STEP_END, kind 2: event and STEP_END raised together
  task automatic applyStimulus(input int kind, input logic [9:0] addr, input bit pulse_start);
    bit last;
    last = 1'b0;
    if (kind != 1) modelEvent(int'(addr));
    if (kind != 0) last = modelStep();
    waitReady("wait_ready");
    AER_ADDR  = addr;
    AER_VALID = (kind != 1);
    STEP_END  = (kind != 0);
    @(posedge CLK);
    #1 AER_VALID = 1'b0;
    if (kind == 2) begin
      countEventBusy();
      @(posedge CLK);
      #1;
    end else if (kind == 0) countEventBusy();
    STEP_END = 1'b0;
    if (kind != 0) finishStep(last, pulse_start);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total_checks = 0; passed_checks = 0; done_seen = 0; done_exp = 0;
    model_step = 0; last_pre = 0; seed = 4'd3;
    RST = 1'b1; START = 1'b0; AER_VALID = 1'b0; STEP_END = 1'b0; AER_ADDR = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_outputs", 64'({AER_READY, CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS,
      SYN_ADDR, CTRL_PRE_NEUR_CS, CTRL_PRE_NEUR_WE, CTRL_POST_NEUR_CS, CTRL_POST_NEUR_WE,
      CTRL_PRE_CNT_EN, CTRL_NEUR_EVENT, CTRL_TSTEP_EVENT, CTRL_TREF_EVENT, SPK_VALID,
      SPK_GRP, SPK_MASK, BUSY, DONE}), 64'd0);
    RST = 1'b0;

    $display("[TB] directed sample: event 5, event with STEP_END, START while busy");
    startSample();
    applyStimulus(0, 10'd5, 1'b0);
    applyStimulus(2, 10'd100, 1'b0);
    applyStimulus(1, 10'd0, 1'b1);

    $display("[TB] STEP_END-only sample");
    seed = 4'($urandom);
    startSample();
    applyStimulus(1, 10'd0, 1'b0);
    applyStimulus(1, 10'd0, 1'b0);

    for (int s = 0; s < 3; s++) begin
      seed = 4'($urandom);
      $display("[TB] random sample %0d seed %0d", s, seed);
      startSample();
      for (int t = 0; t < TS; t++) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int k = 0; k < n; k++) applyStimulus(0, 10'($urandom_range(0, NIN - 1)), 1'b0);
        applyStimulus(1, 10'd0, 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] reset in the middle of a post write sweep");
    startSample();
    modelEvent(7);
    waitReady("reset_test_ready");
    AER_ADDR = 10'd7;
    AER_VALID = 1'b1;
    @(posedge CLK);
    #1 AER_VALID = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge CLK);
        if (CTRL_POST_NEUR_WE && CTRL_POST_NEURON_ADDRESS == 10'd68) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) failTimeout("reach_grp17");
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("mid_sweep_reset", 64'({AER_READY, CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS,
      SYN_ADDR, CTRL_PRE_NEUR_CS, CTRL_PRE_NEUR_WE, CTRL_POST_NEUR_CS, CTRL_POST_NEUR_WE,
      CTRL_PRE_CNT_EN, CTRL_NEUR_EVENT, CTRL_TSTEP_EVENT, CTRL_TREF_EVENT, SPK_VALID,
      SPK_GRP, SPK_MASK, BUSY, DONE}), 64'd0);
    RST = 1'b0;
    post_q.delete();
    last_pre = 0;
    model_step = 0;

    seed = 4'($urandom);
    startSample();
    applyStimulus(0, 10'($urandom_range(0, NIN - 1)), 1'b0);
    applyStimulus(1, 10'd0, 1'b0);
    applyStimulus(0, 10'd783, 1'b0);
    applyStimulus(1, 10'd0, 1'b1);

    repeat (4) @(negedge CLK);
    checkOutput("post_queue_drained", 64'(post_q.size()), 64'd0);
    checkOutput("pre_queue_drained", 64'(pre_q.size()), 64'd0);
    checkOutput("total_done_pulses", 64'(done_seen), 64'(done_exp));
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
